// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_pkg                                                                   |
// | Shared defaults, depth helpers and the flag bundle type for sync_fifo.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDR_WIDTH    = 4;
  localparam int DEFAULT_AEMPTY_THRESH = 2;

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } fifo_flags_t;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int addr_width_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo_mem                                                              |
// | Storage array with a gated write port and a registered, gated read port.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int c_depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array is deliberately left without reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo                                                                  |
// | Single-clock FIFO: pointers, occupancy, registered flags and sticky errors.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH  = depth_of(ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam fifo_flags_t c_flags_rst = '{
    full:   1'b0,
    afull:  (AFULL_THRESH <= 0),
    empty:  1'b1,
    aempty: (AEMPTY_THRESH >= 0)
  };

  logic [ADDR_WIDTH:0] r_wptr;
  logic [ADDR_WIDTH:0] r_rptr;
  logic [ADDR_WIDTH:0] r_count;
  fifo_flags_t         r_flags;
  logic                r_rvalid;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_we;
  logic                w_re;
  logic [ADDR_WIDTH:0] w_wptr_nxt;
  logic [ADDR_WIDTH:0] w_rptr_nxt;
  logic [ADDR_WIDTH:0] w_count_nxt;
  fifo_flags_t         w_flags_nxt;

  // Acceptance uses the registered flags, so a full FIFO still pops and an
  // empty one still pushes when both requests arrive together.
  assign w_we = winc & ~r_flags.full  & ~clr;
  assign w_re = rinc & ~r_flags.empty & ~clr;

  always_comb begin
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (clr) begin
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      w_wptr_nxt  = r_wptr  + {{ADDR_WIDTH{1'b0}}, w_we};
      w_rptr_nxt  = r_rptr  + {{ADDR_WIDTH{1'b0}}, w_re};
      w_count_nxt = r_count + {{ADDR_WIDTH{1'b0}}, w_we} - {{ADDR_WIDTH{1'b0}}, w_re};
    end
  end

  // Flags are derived from next-state values so they settle on the same edge.
  always_comb begin
    w_flags_nxt.full   = (w_wptr_nxt[ADDR_WIDTH] != w_rptr_nxt[ADDR_WIDTH]) &&
                         (w_wptr_nxt[ADDR_WIDTH-1:0] == w_rptr_nxt[ADDR_WIDTH-1:0]);
    w_flags_nxt.empty  = (w_wptr_nxt == w_rptr_nxt);
    w_flags_nxt.afull  = (int'(w_count_nxt) >= AFULL_THRESH);
    w_flags_nxt.aempty = (int'(w_count_nxt) <= AEMPTY_THRESH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_flags     <= c_flags_rst;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_count_nxt;
      r_flags  <= w_flags_nxt;
      r_rvalid <= w_re;
      if (clr) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        r_overflow  <= r_overflow  | (winc & r_flags.full);
        r_underflow <= r_underflow | (rinc & r_flags.empty);
      end
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (r_wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (w_re),
    .raddr (r_rptr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  assign wfull         = r_flags.full;
  assign walmost_full  = r_flags.afull;
  assign rempty        = r_flags.empty;
  assign ralmost_empty = r_flags.aempty;
  assign count         = r_count;
  assign rvalid        = r_rvalid;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sync_fifo                                                               |
// | Self-checking bench: directed scenarios plus random traffic vs a queue.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sync_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       winc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rinc = 1'b0;
  logic       wfull, walmost_full, rvalid, rempty, ralmost_empty, overflow, underflow;
  logic [7:0] rdata;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of words plus the registered read side.
  logic [7:0] m_q[$];
  logic [7:0] m_rdata;
  logic       m_rvalid, m_ovf, m_unf;

  sync_fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .rinc          (rinc),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_rdata  = 8'h00;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  // Drive one cycle of inputs, step the model, and land 1 time unit after the edge.
  task automatic cycle(input bit w, input bit r, input bit c, input logic [7:0] d);
    bit was_full, was_empty;
    winc = w; rinc = r; clr = c; wdata = d;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (c) begin
      m_q.delete();
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      m_rvalid = 1'b0;
      if (r && !was_empty) begin
        m_rdata  = m_q.pop_front();
        m_rvalid = 1'b1;
      end
      if (r && was_empty) m_unf = 1'b1;
      if (w && !was_full) m_q.push_back(d);
      if (w && was_full) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    winc = 0; rinc = 0; clr = 0; wdata = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wfull, walmost_full, rempty, ralmost_empty} !== 4'b0011) begin
      errors++; $display("FAIL reset_flags: got %b expected 0011", {wfull, walmost_full, rempty, ralmost_empty});
    end
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    checks++;
    if ({rdata, rvalid, overflow, underflow} !== 11'd0) begin
      errors++; $display("FAIL reset_read: rdata=%0h rvalid=%b ovf=%b unf=%b expected all 0", rdata, rvalid, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 0, 8'(i));
      checks++;
      if (count !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1);
      end
      checks++;
      if ({wfull, walmost_full, rempty} !== {(i + 1 == DEPTH), (i + 1 >= 14), 1'b0}) begin
        errors++; $display("FAIL fill_flags[%0d]: got full/afull/empty=%b expected %b", i,
                           {wfull, walmost_full, rempty}, {(i + 1 == DEPTH), (i + 1 >= 14), 1'b0});
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 0, 8'h00);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 8'(i)) begin
        errors++; $display("FAIL drain_data[%0d]: got rvalid=%b rdata=%0h expected 1/%0h", i, rvalid, rdata, i);
      end
      checks++;
      if (count !== 5'(15 - i) || ralmost_empty !== (15 - i <= 2) || rempty !== (i == 15)) begin
        errors++; $display("FAIL drain_flags[%0d]: got count=%0d aempty=%b empty=%b expected %0d/%b/%b",
                           i, count, ralmost_empty, rempty, 15 - i, (15 - i <= 2), (i == 15));
      end
    end
    cycle(0, 0, 0, 8'h00);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 8'h0F) begin
      errors++; $display("FAIL drain_idle: got rvalid=%b rdata=%0h expected 0/0f", rvalid, rdata);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q[$];
    int n_w[2] = '{10, 16};
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < n_w[p]; i++) begin
        logic [7:0] d = 8'($urandom);
        exp_q.push_back(d);
        cycle(1, 0, 0, d);
      end
      for (int i = 0; i < n_w[p]; i++) begin
        logic [7:0] e = exp_q.pop_front();
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (rvalid !== 1'b1 || rdata !== e) begin
          errors++; $display("FAIL wrap_data[%0d.%0d]: got rvalid=%b rdata=%0h expected 1/%0h", p, i, rvalid, rdata, e);
        end
      end
    end
    checks++;
    if ({overflow, underflow, rempty} !== 3'b001) begin
      errors++; $display("FAIL wrap_errs: got ovf/unf/empty=%b expected 001", {overflow, underflow, rempty});
    end
  endtask

  task automatic test_full_both();
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'(8'h30 + i));
    cycle(1, 1, 0, 8'hEE);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'h30) begin
      errors++; $display("FAIL full_both_data: got rvalid=%b rdata=%0h expected 1/30", rvalid, rdata);
    end
    checks++;
    if (count !== 5'd15 || overflow !== 1'b1 || wfull !== 1'b0) begin
      errors++; $display("FAIL full_both_state: got count=%0d ovf=%b full=%b expected 15/1/0", count, overflow, wfull);
    end
  endtask

  task automatic test_empty_both();
    cycle(0, 0, 1, 8'h00);
    cycle(1, 1, 0, 8'hA5);
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || rvalid !== 1'b0 || rempty !== 1'b0) begin
      errors++; $display("FAIL empty_both_state: got count=%0d unf=%b rvalid=%b empty=%b expected 1/1/0/0",
                         count, underflow, rvalid, rempty);
    end
    cycle(0, 1, 0, 8'h00);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'hA5) begin
      errors++; $display("FAIL empty_both_read: got rvalid=%b rdata=%0h expected 1/a5", rvalid, rdata);
    end
  endtask

  task automatic test_clr();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'(8'h40 + i));
    cycle(1, 0, 0, 8'hFF);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 8'h00);
    checks++;
    if (count !== 5'd7 || overflow !== 1'b1 || rdata !== 8'h48) begin
      errors++; $display("FAIL clr_setup: got count=%0d ovf=%b rdata=%0h expected 7/1/48", count, overflow, rdata);
    end
    cycle(1, 1, 1, 8'h11);
    checks++;
    if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL clr_state: got count=%0d empty=%b full=%b ovf=%b unf=%b expected 0/1/0/0/0",
                         count, rempty, wfull, overflow, underflow);
    end
    checks++;
    if (rvalid !== 1'b0 || rdata !== 8'h48) begin
      errors++; $display("FAIL clr_read: got rvalid=%b rdata=%0h expected 0/48", rvalid, rdata);
    end
  endtask

  task automatic test_random();
    int pw = 50, pr = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        pw = $urandom_range(15, 85);
        pr = 100 - pw;
      end
      cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            $urandom_range(0, 199) == 0, 8'($urandom));
      checks++;
      if (count !== 5'(m_q.size())) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, count, m_q.size());
      end
      checks++;
      if ({wfull, walmost_full, rempty, ralmost_empty} !==
          {(m_q.size() == DEPTH), (m_q.size() >= 14), (m_q.size() == 0), (m_q.size() <= 2)}) begin
        errors++; $display("FAIL rand_flags[%0d]: got %b for count %0d", n,
                           {wfull, walmost_full, rempty, ralmost_empty}, m_q.size());
      end
      checks++;
      if (rvalid !== m_rvalid || rdata !== m_rdata) begin
        errors++; $display("FAIL rand_read[%0d]: got %b/%0h expected %b/%0h", n, rvalid, rdata, m_rvalid, m_rdata);
      end
      checks++;
      if ({overflow, underflow} !== {m_ovf, m_unf}) begin
        errors++; $display("FAIL rand_errs[%0d]: got %b expected %b", n, {overflow, underflow}, {m_ovf, m_unf});
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 0, 0, 8'h61);
    cycle(1, 0, 0, 8'h62);
    cycle(1, 1, 0, 8'h63);
    winc = 1'b1; rinc = 1'b1; wdata = 8'h64;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wfull, walmost_full, rempty, ralmost_empty} !== 4'b0011 || count !== 5'd0) begin
      errors++; $display("FAIL async_rst_flags: got flags=%b count=%0d expected 0011/0",
                         {wfull, walmost_full, rempty, ralmost_empty}, count);
    end
    checks++;
    if ({rdata, rvalid, overflow, underflow} !== 11'd0) begin
      errors++; $display("FAIL async_rst_read: got rdata=%0h rvalid=%b ovf=%b unf=%b expected 0", rdata, rvalid, overflow, underflow);
    end
    winc = 0; rinc = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 8'h77);
    cycle(0, 1, 0, 8'h00);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'h77 || count !== 5'd0) begin
      errors++; $display("FAIL async_rst_after: got rvalid=%b rdata=%0h count=%0d expected 1/77/0", rvalid, rdata, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_both();
    test_empty_both();
    test_clr();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock FIFO with its own storage array and a registered read port.
- Generalises the asynchronous FIFO's dual-port memory into a complete buffer:
  - full and empty flags
  - programmable almost-full and almost-empty thresholds
  - occupancy count
  - sticky overflow and underflow error flags
  - synchronous clear
- Used wherever producer and consumer share one clock; no pointer synchronisers are needed.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: address width; FIFO_DEPTH = 1 << ADDR_WIDTH.
- AFULL_THRESH, FIFO_DEPTH-2: walmost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2: ralmost_empty asserts when count <= AEMPTY_THRESH.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- clr  input  1  synchronous flush; empties the FIFO and clears the error flags.
- winc  input  1  write request.
- wdata  input  DATA_WIDTH  write data.
- wfull  output  1  FIFO full.
- walmost_full  output  1  count >= AFULL_THRESH.
- rinc  input  1  read request.
- rdata  output  DATA_WIDTH  read data, registered.
- rvalid  output  1  rdata holds the word popped on the previous cycle.
- rempty  output  1  FIFO empty.
- ralmost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0 to FIFO_DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous assert):
  - wptr, rptr = 0; count = 0.
  - rempty = 1, wfull = 0, ralmost_empty = 1, walmost_full = 0 (for AFULL_THRESH > 0).
  - rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Pointers:
  - wptr and rptr are binary, ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address memory; the MSB is the wrap bit.
  - Full when MSBs differ and lower bits are equal.
  - Empty when the pointers are equal.
  - Wrap from FIFO_DEPTH-1 to 0 is natural modulo arithmetic.
- Write acceptance: we = winc & ~wfull.
  - On an accepted write, mem[wptr[ADDR_WIDTH-1:0]] <= wdata and wptr increments.
  - winc while wfull: write dropped, overflow <= 1.
- Read acceptance: re = rinc & ~rempty.
  - On an accepted read, rdata <= mem[rptr[ADDR_WIDTH-1:0]], rptr increments, rvalid <= 1 next cycle.
  - Otherwise rvalid <= 0 and rdata holds its value.
  - rinc while rempty: read dropped, underflow <= 1.
  - Read latency is 1 cycle.
- Flags:
  - All flags are registered and updated in the same edge as the pointers.
  - No combinational path from winc/rinc to any output.
- count: next = count + we - re.
  - Simultaneous accepted read and write leaves count unchanged.
- Simultaneous winc & rinc:
  - When full: read accepted, write rejected (flags are evaluated before the edge); overflow set.
  - When empty: write accepted, read rejected; underflow set; the FIFO becomes non-empty next cycle.
  - Otherwise both are accepted.
  - A read of the address being written in the same cycle is impossible unless the FIFO is empty, which is excluded above.
- clr (synchronous, overrides winc/rinc in that cycle):
  - pointers and count = 0, rempty = 1, wfull = 0.
  - rvalid = 0, overflow = 0, underflow = 0; rdata holds.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight reads are discarded.

Decomposition:
- Package fifo_pkg holds:
  - function clog2-based depth helpers.
  - localparam defaults.
  - typedef struct packed {logic full, afull, empty, aempty;} fifo_flags_t, used for flag bundles.
- Sub-module sync_fifo_mem:
  - Parameterised storage array.
  - Write port gated by we.
  - Registered read port gated by re.
  - No reset on the array.
- Top level holds pointers, count, flags and error logic.

Test Plan (defaults: DATA_WIDTH 8, ADDR_WIDTH 4):
- Reset then fill: 16 writes 0x00..0x0F -> wfull = 1 after the 16th; walmost_full from count 14; count = 16; rempty = 0.
- Drain: 16 reads -> rdata 0x00..0x0F, each one cycle after its rinc with rvalid = 1; rempty = 1 after the last; ralmost_empty from count 2.
- Wrap: write 10, read 10, write 16, read 16 -> data in order across the pointer wrap; no overflow or underflow.
- Full with winc & rinc together -> read returns the oldest word, write rejected, overflow = 1, count goes 16 -> 15.
- Empty with winc & rinc together -> write of 0xA5 accepted, underflow = 1, rvalid = 0; the next read returns 0xA5.
- clr with count = 7 and overflow = 1 -> next cycle count = 0, rempty = 1, overflow = 0.
- rst_n pulsed mid-burst -> outputs reach reset values without waiting for a clock edge.
